branch_cmp_pipe: RTL and testbench

- Parametrised, pipelined branch-condition unit for the P6 datapath; successor to the single-cycle equality/sign comparator.
- Evaluates one of eight MIPS branch/set conditions on two WIDTH-bit operands and delivers the result LATENCY cycles later.
- Honours the hazard unit's stall and flush controls. Sits between the D-stage operand forwarding muxes and the NPC/branch-resolution logic.

---
 rtl/branch_cmp_pipe.sv | 136 +++++++++++++
 tb/tb_branch_cmp_pipe.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cmp_pipe.sv
// Pipelined MIPS branch/set condition unit: eight compare modes, LATENCY register stages,
// hazard-unit stall/flush. Optional taken-result counter under macro BRANCH_STAT_EN.
module branch_cmp_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  input  logic             valid_in,
  input  logic             stall,
  input  logic             flush,
  output logic             valid_out,
  output logic             taken,
  output logic             eq,
  output logic             eqz,
  output logic             ltz
`ifdef BRANCH_STAT_EN
  ,
  output logic [CNT_W-1:0] taken_cnt
`endif
);

  typedef enum logic [2:0] {
    MODE_EQ  = 3'd0,
    MODE_NE  = 3'd1,
    MODE_LEZ = 3'd2,
    MODE_GTZ = 3'd3,
    MODE_LTZ = 3'd4,
    MODE_GEZ = 3'd5,
    MODE_LT  = 3'd6,
    MODE_LTU = 3'd7
  } mode_e;

  typedef struct packed {
    logic valid;
    logic taken;
    logic eq;
    logic eqz;
    logic ltz;
  } stage_t;

  stage_t s1_d;
  stage_t stage_d [LATENCY];
  stage_t stage_q [LATENCY];

  logic eq_c, eqz_c, ltz_c, lt_c, ltu_c, cond_c;

  // Flag computation for the capture stage; an invalid slot carries all-zero flags.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    s1_d   = '0;
    eq_c   = (a == b);
    eqz_c  = (a == '0);
    ltz_c  = a[WIDTH-1];
    lt_c   = ($signed(a) < $signed(b));
    ltu_c  = (a < b);
    cond_c = 1'b0;
    case (mode_e'(mode))
      MODE_EQ:  cond_c = eq_c;
      MODE_NE:  cond_c = ~eq_c;
      MODE_LEZ: cond_c = ltz_c | eqz_c;
      MODE_GTZ: cond_c = ~ltz_c & ~eqz_c;
      MODE_LTZ: cond_c = ltz_c;
      MODE_GEZ: cond_c = ~ltz_c;
      MODE_LT:  cond_c = lt_c;
      MODE_LTU: cond_c = ltu_c;
      default:  cond_c = 1'b0;
    endcase
    if (valid_in) begin
      s1_d = '{valid: 1'b1, taken: cond_c, eq: eq_c, eqz: eqz_c, ltz: ltz_c};
    end
  end

  // Flush beats stall, so inputs presented while both are high are dropped.
  always_comb begin
    for (int k = 0; k < LATENCY; k++) begin
      stage_d[k] = stage_q[k];
    end
    if (flush) begin
      for (int k = 0; k < LATENCY; k++) begin
        stage_d[k] = '0;
      end
    end else if (!stall) begin
      stage_d[0] = s1_d;
      for (int k = 1; k < LATENCY; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    if (reset) begin
      for (int k = 0; k < LATENCY; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LATENCY; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign valid_out = stage_q[LATENCY-1].valid;
  assign taken     = stage_q[LATENCY-1].taken;
  assign eq        = stage_q[LATENCY-1].eq;
  assign eqz       = stage_q[LATENCY-1].eqz;
  assign ltz       = stage_q[LATENCY-1].ltz;

`ifdef BRANCH_STAT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // A result is consumed only on an edge where it actually leaves the final stage.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_out && taken && !stall && !flush) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign taken_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Directed self-checking bench for branch_cmp_pipe: four instances (LATENCY 1/2/3, WIDTH 8)
// share one set of drivers; each scenario task checks the instance it targets.
module tb_branch_cmp_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [2:0]  mode;
  logic        valid_in, stall, flush;

  logic vo1, tk1, eq1, ez1, lz1;
  logic vo2, tk2, eq2, ez2, lz2;
  logic vo3, tk3, eq3, ez3, lz3;
  logic vo8, tk8, eq8, ez8, lz8;
`ifdef BRANCH_STAT_EN
  logic [3:0]  cnt1;
  logic [31:0] cnt2, cnt3;
  logic [31:0] cnt8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_cmp_pipe #(.WIDTH(32), .LATENCY(1), .CNT_W(4)) u_l1 (
    .clk(clk), .reset(reset), .a(a), .b(b), .mode(mode), .valid_in(valid_in),
    .stall(stall), .flush(flush), .valid_out(vo1), .taken(tk1), .eq(eq1), .eqz(ez1), .ltz(lz1)
`ifdef BRANCH_STAT_EN
    , .taken_cnt(cnt1)
`endif
  );

  branch_cmp_pipe #(.WIDTH(32), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .a(a), .b(b), .mode(mode), .valid_in(valid_in),
    .stall(stall), .flush(flush), .valid_out(vo2), .taken(tk2), .eq(eq2), .eqz(ez2), .ltz(lz2)
`ifdef BRANCH_STAT_EN
    , .taken_cnt(cnt2)
`endif
  );

  branch_cmp_pipe #(.WIDTH(32), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .a(a), .b(b), .mode(mode), .valid_in(valid_in),
    .stall(stall), .flush(flush), .valid_out(vo3), .taken(tk3), .eq(eq3), .eqz(ez3), .ltz(lz3)
`ifdef BRANCH_STAT_EN
    , .taken_cnt(cnt3)
`endif
  );

  branch_cmp_pipe #(.WIDTH(8), .LATENCY(1)) u_w8 (
    .clk(clk), .reset(reset), .a(a[7:0]), .b(b[7:0]), .mode(mode), .valid_in(valid_in),
    .stall(stall), .flush(flush), .valid_out(vo8), .taken(tk8), .eq(eq8), .eqz(ez8), .ltz(lz8)
`ifdef BRANCH_STAT_EN
    , .taken_cnt(cnt8)
`endif
  );

  wire [4:0] out1 = {vo1, tk1, eq1, ez1, lz1};
  wire [4:0] out2 = {vo2, tk2, eq2, ez2, lz2};
  wire [4:0] out3 = {vo3, tk3, eq3, ez3, lz3};
  wire [4:0] out8 = {vo8, tk8, eq8, ez8, lz8};

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  mode;
    logic        t;
    logic        eq;
    logic        eqz;
    logic        ltz;
  } vec_t;

  // Hand-computed {taken, eq, eqz, ltz} per operand pair and mode.
  vec_t vecs [24] = '{
    '{32'h8000_0000, 32'h1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1},
    '{32'h8000_0000, 32'h1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1},
    '{32'h8000_0000, 32'h1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1},
    '{32'h8000_0000, 32'h1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1},
    '{32'h8000_0000, 32'h1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1},
    '{32'h8000_0000, 32'h1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1},
    '{32'h8000_0000, 32'h1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1},
    '{32'h8000_0000, 32'h1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1},
    '{32'h5,         32'h5, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0},
    '{32'h5,         32'h5, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0},
    '{32'h0,         32'h9, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0},
    '{32'h0,         32'h9, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0},
    '{32'h0,         32'h9, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0},
    '{32'h1,         32'h0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'h1,         32'h0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'h3,         32'h7, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'h3,         32'h7, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'h7,         32'h3, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'hFFFF_FFFF, 32'h1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1},
    '{32'hFFFF_FFFF, 32'h1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1},
    '{32'h1, 32'hFFFF_FFFF, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'h0,         32'h0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0},
    '{32'h8000_0000, 32'h0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1},
    '{32'h7FFF_FFFF, 32'h0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0}
  };

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv,
                       input logic [2:0] m);
    valid_in = v;
    a        = av;
    b        = bv;
    mode     = m;
  endtask

  task automatic drain();
    drive(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 3'd1);
    stall = 1'b0;
    flush = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 32'h5, 32'h5, 3'd0);
    repeat (2) step();
    checks++;
    if ({out1, out2, out3, out8} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", {out1, out2, out3, out8}, 20'h0);
    end
    reset = 1'b0;
    drain();
  endtask

  task automatic test_mode_sweep();
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].mode);
      step();
      checks++;
      if (out1 !== {1'b1, vecs[i].t, vecs[i].eq, vecs[i].eqz, vecs[i].ltz}) begin
        errors++;
        $display("FAIL mode_sweep[%0d] a=%h b=%h mode=%0d: got %b expected %b", i, vecs[i].a,
                 vecs[i].b, vecs[i].mode, out1,
                 {1'b1, vecs[i].t, vecs[i].eq, vecs[i].eqz, vecs[i].ltz});
      end
    end
    drain();
  endtask

  task automatic test_pipeline();
    logic [4:0] exp2 [5] = '{5'b00000, 5'b11100, 5'b11010, 5'b00000, 5'b00000};
    logic [4:0] exp3 [5] = '{5'b00000, 5'b00000, 5'b11100, 5'b11010, 5'b00000};
    for (int e = 0; e < 5; e++) begin
      if (e == 0)      drive(1'b1, 32'h5, 32'h5, 3'd0);
      else if (e == 1) drive(1'b1, 32'h0, 32'h5, 3'd2);
      else             drive(1'b0, 32'h7, 32'h7, 3'd0);
      step();
      checks++;
      if (out3 !== exp3[e]) begin
        errors++;
        $display("FAIL pipeline_l3_edge%0d: got %b expected %b", e, out3, exp3[e]);
      end
      checks++;
      if (out2 !== exp2[e]) begin
        errors++;
        $display("FAIL pipeline_l2_edge%0d: got %b expected %b", e, out2, exp2[e]);
      end
    end
    drain();
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 32'h5, 32'h5, 3'd0);
    step();
    checks++;
    if (out1 !== 5'b11100) begin
      errors++;
      $display("FAIL stall_pre: got %b expected %b", out1, 5'b11100);
    end
    stall = 1'b1;
    drive(1'b1, 32'h0, 32'h1, 3'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out1 !== 5'b11100) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %b expected %b", i, out1, 5'b11100);
      end
    end
    flush = 1'b1;
    drive(1'b1, 32'h5, 32'h5, 3'd0);
    step();
    checks++;
    if (out1 !== 5'b00000) begin
      errors++;
      $display("FAIL flush_stall: got %b expected %b", out1, 5'b00000);
    end
    flush = 1'b0;
    stall = 1'b0;
    drive(1'b0, 32'h5, 32'h5, 3'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({out1, out3} !== 10'h0) begin
        errors++;
        $display("FAIL flush_dropped[%0d]: got %b expected %b", i, {out1, out3}, 10'h0);
      end
    end
    drain();
  endtask

  task automatic test_stall_pipeline();
    logic [4:0] exp3 [6] = '{5'b0, 5'b0, 5'b0, 5'b0, 5'b11100, 5'b0};
    for (int e = 0; e < 6; e++) begin
      stall = (e == 1 || e == 2);
      if (e == 0)     drive(1'b1, 32'h5, 32'h5, 3'd0);
      else if (stall) drive(1'b1, 32'h0, 32'h0, 3'd1);
      else            drive(1'b0, 32'h3, 32'h3, 3'd0);
      step();
      checks++;
      if (out3 !== exp3[e]) begin
        errors++;
        $display("FAIL stall_l3_edge%0d: got %b expected %b", e, out3, exp3[e]);
      end
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 32'h5, 32'h5, 3'd0);
    step();
    drive(1'b1, 32'h0, 32'h9, 3'd2);
    step();
    checks++;
    if (out2 !== 5'b11100) begin
      errors++;
      $display("FAIL midflight_pre: got %b expected %b", out2, 5'b11100);
    end
    reset = 1'b1;
    drive(1'b1, 32'h0, 32'h0, 3'd0);
    step();
    checks++;
    if ({out2, out3} !== 10'h0) begin
      errors++;
      $display("FAIL midflight_reset: got %b expected %b", {out2, out3}, 10'h0);
    end
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({vo2, vo3} !== 2'b00) begin
        errors++;
        $display("FAIL midflight_after[%0d]: got %b expected %b", i, {vo2, vo3}, 2'b00);
      end
    end
    drain();
  endtask

  task automatic test_width8_bubbles();
    drive(1'b1, 32'hFF, 32'h01, 3'd6);
    step();
    checks++;
    if (out8 !== 5'b11001) begin
      errors++;
      $display("FAIL w8_lt: got %b expected %b", out8, 5'b11001);
    end
    drive(1'b1, 32'hFF, 32'h01, 3'd7);
    step();
    checks++;
    if (out8 !== 5'b10001) begin
      errors++;
      $display("FAIL w8_ltu: got %b expected %b", out8, 5'b10001);
    end
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) drive(1'b1, 32'h3C, 32'h3C, 3'd0);
      else            drive(1'b0, 32'hA5, 32'h3C, 3'd1);
      step();
      checks++;
      if (out8 !== ((i % 2 == 0) ? 5'b11100 : 5'b00000)) begin
        errors++;
        $display("FAIL w8_bubble[%0d]: got %b expected %b", i, out8,
                 ((i % 2 == 0) ? 5'b11100 : 5'b00000));
      end
    end
    drain();
  endtask

`ifdef BRANCH_STAT_EN
  task automatic test_taken_cnt();
    reset = 1'b1;
    step();
    checks++;
    if (cnt1 !== 4'd0) begin
      errors++;
      $display("FAIL cnt_reset: got %0d expected %0d", cnt1, 0);
    end
    reset = 1'b0;
    drive(1'b1, 32'h5, 32'h5, 3'd0);
    repeat (17) step();
    drive(1'b0, 32'h5, 32'h5, 3'd0);
    step();
    checks++;
    if (cnt1 !== 4'd1) begin
      errors++;
      $display("FAIL cnt_wrap: got %0d expected %0d", cnt1, 1);
    end
    drive(1'b1, 32'h5, 32'h5, 3'd0);
    step();
    stall = 1'b1;
    drive(1'b0, 32'h5, 32'h5, 3'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (cnt1 !== 4'd1) begin
        errors++;
        $display("FAIL cnt_stall[%0d]: got %0d expected %0d", i, cnt1, 1);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (cnt1 !== 4'd2) begin
      errors++;
      $display("FAIL cnt_release: got %0d expected %0d", cnt1, 2);
    end
    drive(1'b1, 32'h5, 32'h5, 3'd0);
    step();
    flush = 1'b1;
    drive(1'b0, 32'h5, 32'h5, 3'd0);
    step();
    flush = 1'b0;
    step();
    checks++;
    if (cnt1 !== 4'd2) begin
      errors++;
      $display("FAIL cnt_flush: got %0d expected %0d", cnt1, 2);
    end
    drain();
  endtask
`endif

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 3'd0);
    test_reset();
    test_mode_sweep();
    test_pipeline();
    test_stall_flush();
    test_stall_pipeline();
    test_reset_midflight();
    test_width8_bubbles();
`ifdef BRANCH_STAT_EN
    test_taken_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
